// File: rtl/song_pkg.sv
// Shared types for the song sequencer: note code, table entry layout and FSM states.
package song_pkg;

    localparam int unsigned SONG_DUR_BITS = 16;

    typedef logic [2:0] note_t;
    localparam note_t NOTE_REST = 3'd0;

    // Entry layout at the default duration width.
    typedef struct packed {
        note_t                    note;
        logic [SONG_DUR_BITS-1:0] dur;
    } song_entry_t;

    typedef enum logic [1:0] {StIdle, StArm, StWait, StRestart} state_e;

endpackage

// File: rtl/song_table.sv
// Song table register file: one write port, combinational read, async clear to end markers.
module song_table
    import song_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned DUR_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  note_t                wr_note,
    input  logic [DUR_BITS-1:0]  wr_dur,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output note_t                rd_note,
    output logic [DUR_BITS-1:0]  rd_dur
);

    localparam int unsigned Depth = 2 ** ADDR_BITS;

    note_t               note_q [Depth];
    logic [DUR_BITS-1:0] dur_q  [Depth];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Depth; i++) begin
                note_q[i] <= NOTE_REST;
                dur_q[i]  <= '0;
            end
        end else if (wr_en) begin
            note_q[wr_addr] <= wr_note;
            dur_q[wr_addr]  <= wr_dur;
        end
    end

    assign rd_note = note_q[rd_addr];
    assign rd_dur  = dur_q[rd_addr];

endmodule

// File: rtl/song_sequencer.sv
// Walks the song table and issues one play_load per entry, timed off the player's play_done.
module song_sequencer
    import song_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 4,
    parameter int unsigned DUR_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [2:0]           wr_note,
    input  logic [DUR_BITS-1:0]  wr_duration,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop,
    output logic                 play_load,
    output logic [2:0]           play_note,
    output logic [DUR_BITS-1:0]  play_duration,
    input  logic                 play_done,
    output logic                 busy,
    output logic [ADDR_BITS-1:0] cur_index,
    output logic                 song_done
);

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [ADDR_BITS-1:0] cur_q, cur_d;
    logic                 wrapped_q, wrapped_d;
    logic                 valid;

    song_table #(
        .ADDR_BITS (ADDR_BITS),
        .DUR_BITS  (DUR_BITS)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_note (wr_note),
        .wr_dur  (wr_duration),
        .rd_addr (ptr_q),
        .rd_note (play_note),
        .rd_dur  (play_duration)
    );

    assign valid = (play_duration != '0);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cur_d     = cur_q;
        wrapped_d = wrapped_q;
        play_load = 1'b0;
        song_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && valid && !stop) play_load = 1'b1;
                else if (start && !valid)    song_done = 1'b1;
            end
            StArm: begin
                // play_done is still high in the load cycle; wait until the player takes the note.
                if (!stop && !play_done) state_d = StWait;
            end
            StWait: begin
                if (!stop && play_done) begin
                    if (valid && !wrapped_q) begin
                        play_load = 1'b1;
                    end else begin
                        ptr_d     = '0;
                        wrapped_d = 1'b0;
                        if (loop) begin
                            state_d = StRestart;
                        end else begin
                            song_done = 1'b1;
                            state_d   = StIdle;
                        end
                    end
                end
            end
            StRestart: begin
                if (!stop) begin
                    if (valid) begin
                        play_load = 1'b1;
                    end else begin
                        song_done = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (stop && state_q != StIdle) begin
            state_d   = StIdle;
            ptr_d     = '0;
            wrapped_d = 1'b0;
        end else if (play_load) begin
            cur_d   = ptr_q;
            ptr_d   = ptr_q + 1'b1;
            state_d = StArm;
            if (ptr_q == {ADDR_BITS{1'b1}}) wrapped_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            cur_q     <= '0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cur_q     <= cur_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign cur_index = cur_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer driving a small behavioural note player.
module tb_song_sequencer;

    localparam int unsigned AB = 4;
    localparam int unsigned DB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AB-1:0] wr_addr;
    logic [2:0]    wr_note;
    logic [DB-1:0] wr_duration;
    logic          start, stop, loop;
    logic          play_load;
    logic [2:0]    play_note;
    logic [DB-1:0] play_duration;
    logic          play_done;
    logic          busy;
    logic [AB-1:0] cur_index;
    logic          song_done;

    song_sequencer #(
        .ADDR_BITS (AB),
        .DUR_BITS  (DB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_note       (wr_note),
        .wr_duration   (wr_duration),
        .start         (start),
        .stop          (stop),
        .loop          (loop),
        .play_load     (play_load),
        .play_note     (play_note),
        .play_duration (play_duration),
        .play_done     (play_done),
        .busy          (busy),
        .cur_index     (cur_index),
        .song_done     (song_done)
    );

    always #5 clk = ~clk;

    // Player: plays a note for `duration` cycles, done is high when idle.
    logic [DB-1:0] pcnt;
    logic [2:0]    pnote;
    logic [2:0]    note_sel;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt  <= '0;
            pnote <= '0;
        end else if (play_load) begin
            pcnt  <= play_duration;
            pnote <= play_note;
        end else if (pcnt != '0) begin
            pcnt <= pcnt - 1'b1;
        end
    end

    assign play_done = (pcnt == '0);
    assign note_sel  = (pcnt != '0) ? pnote : 3'd0;

    int errors = 0;
    int checks = 0;
    int loads  = 0;
    int dones  = 0;
    int l0, d0;

    always @(posedge clk) begin
        if (!rst) begin
            if (play_load) loads <= loads + 1;
            if (song_done) dones <= dones + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Check one cycle's outputs mid-cycle, then advance to just after the next edge.
    task automatic step(input string tag, input bit ld, input int pn, input int ns,
                        input bit sd, input bit bz);
        #2;
        check({tag, ".load"}, 32'(play_load), 32'(ld));
        if (ld) check({tag, ".note"}, 32'(play_note), 32'(pn));
        check({tag, ".note_sel"}, 32'(note_sel), 32'(ns));
        check({tag, ".song_done"}, 32'(song_done), 32'(sd));
        check({tag, ".busy"}, 32'(busy), 32'(bz));
        cyc();
    endtask

    task automatic write_entry(input int a, input int n, input int d);
        wr_en       = 1'b1;
        wr_addr     = AB'(a);
        wr_note     = 3'(n);
        wr_duration = DB'(d);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #12;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; wr_addr = '0; wr_note = '0; wr_duration = '0;
        start = 0; stop = 0; loop = 0;
        #12;
        check("reset.busy", 32'(busy), 0);
        check("reset.load", 32'(play_load), 0);
        check("reset.song_done", 32'(song_done), 0);
        check("reset.cur_index", 32'(cur_index), 0);
        @(posedge clk); #1; rst = 1'b0;

        // Single note
        write_entry(0, 1, 2);
        start = 1;
        #2;
        check("t1.dur", 32'(play_duration), 2);
        step("t1c0", 1, 1, 0, 0, 0);
        start = 0;
        step("t1c1", 0, 0, 1, 0, 1);
        step("t1c2", 0, 0, 1, 0, 1);
        step("t1c3", 0, 0, 0, 1, 1);
        step("t1c4", 0, 0, 0, 0, 0);

        // Seamless three-note sequence
        write_entry(0, 2, 4);
        write_entry(1, 0, 3);
        write_entry(2, 7, 1);
        l0 = loads;
        start = 1;
        step("t2c0", 1, 2, 0, 0, 0);
        start = 0;
        for (int k = 1; k <= 4; k++) step("t2note2", 0, 0, 2, 0, 1);
        check("t2.cur0", 32'(cur_index), 0);
        step("t2c5", 1, 0, 0, 0, 1);
        for (int k = 6; k <= 8; k++) step("t2rest", 0, 0, 0, 0, 1);
        check("t2.cur1", 32'(cur_index), 1);
        step("t2c9", 1, 7, 0, 0, 1);
        step("t2c10", 0, 0, 7, 0, 1);
        check("t2.cur2", 32'(cur_index), 2);
        step("t2c11", 0, 0, 0, 1, 1);
        step("t2c12", 0, 0, 0, 0, 0);
        check("t2.loads", 32'(loads - l0), 3);

        // Looping single note with a one-cycle restart gap
        write_entry(0, 3, 2);
        write_entry(1, 0, 0);
        loop = 1;
        l0 = loads; d0 = dones;
        start = 1;
        step("t3c0", 1, 3, 0, 0, 0);
        start = 0;
        for (int k = 1; k <= 12; k++)
            step("t3loop", (k % 4) == 0, 3, ((k % 4) == 1 || (k % 4) == 2) ? 3 : 0, 0, 1);
        stop = 1;
        step("t3stop", 0, 0, 3, 0, 1);
        stop = 0;
        loop = 0;
        step("t3idle", 0, 0, 3, 0, 0);
        step("t3drain", 0, 0, 0, 0, 0);
        check("t3.loads", 32'(loads - l0), 4);
        check("t3.dones", 32'(dones - d0), 0);

        // Stop mid-note; the player still finishes the note
        write_entry(0, 3, 6);
        write_entry(1, 1, 1);
        write_entry(2, 0, 0);
        l0 = loads;
        start = 1;
        step("t4c0", 1, 3, 0, 0, 0);
        start = 0;
        step("t4c1", 0, 0, 3, 0, 1);
        stop = 1;
        step("t4c2", 0, 0, 3, 0, 1);
        stop = 0;
        for (int k = 3; k <= 6; k++) step("t4tail", 0, 0, 3, 0, 0);
        step("t4c7", 0, 0, 0, 0, 0);
        check("t4.loads", 32'(loads - l0), 1);

        // Empty song after reset
        do_reset();
        start = 1;
        step("t5empty", 0, 0, 0, 1, 0);
        start = 0;
        step("t5after", 0, 0, 0, 0, 0);

        // Full 16-entry table without loop
        for (int i = 0; i < 16; i++) write_entry(i, (i % 7) + 1, 1);
        l0 = loads; d0 = dones;
        start = 1;
        for (int k = 0; k <= 32; k++) begin
            step("t5wrap", (k % 2 == 0) && (k <= 30), ((k / 2) % 7) + 1,
                 (k % 2 == 1) ? ((k / 2) % 7) + 1 : 0, k == 32, k != 0);
            start = 0;
        end
        step("t5end", 0, 0, 0, 0, 0);
        check("t5.loads", 32'(loads - l0), 16);
        check("t5.dones", 32'(dones - d0), 1);
        check("t5.cur15", 32'(cur_index), 15);

        // Asynchronous reset during WAIT
        l0 = loads;
        start = 1;
        step("t6c0", 1, 1, 0, 0, 0);
        start = 0;
        step("t6c1", 0, 0, 1, 0, 1);
        step("t6c2", 1, 2, 0, 0, 1);
        step("t6c3", 0, 0, 2, 0, 1);
        #2;
        check("t6.pre_busy", 32'(busy), 1);
        check("t6.pre_cur", 32'(cur_index), 1);
        check("t6.pre_load", 32'(play_load), 1);
        rst = 1'b1;
        #1;
        check("t6.rst_busy", 32'(busy), 0);
        check("t6.rst_cur", 32'(cur_index), 0);
        check("t6.rst_load", 32'(play_load), 0);
        check("t6.rst_done", 32'(song_done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1;
        step("t6empty", 0, 0, 0, 1, 0);
        start = 0;
        check("t6.loads", 32'(loads - l0), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
